axi_ddr3_bist: RTL and testbench
================================

AXI_DDR3_BIST -- requirements
Module: axi_ddr3_bist

Interface
REQ-001 SHALL have parameter WIDTH, default 32, AXI data width in bits (32, 64 or 128).
REQ-002 SHALL have parameter ADDRS, default 27, AXI byte-address width.
REQ-003 SHALL have parameter REQID, default 4, AXI ID width.
REQ-004 SHALL have parameter BURST_LEN, default 3, AXI awlen/arlen value (beats = BURST_LEN+1, 0..255).
REQ-005 SHALL have parameter CNT_BITS, default 16, width of burst-count and error-count fields.
REQ-006 SHALL have port clock, input, 1, sole clock.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start_i, input, 1, start pulse; ignored unless busy_o=0.
REQ-009 SHALL have port mode_i, input, 2, 00 write+verify, 01 write-only, 10 verify-only, 11 treated as 00.
REQ-010 SHALL have ports base_i (input, ADDRS), bursts_i (input, CNT_BITS), seed_i (input, WIDTH): start address, burst count, LFSR seed; all sampled on accepted start.
REQ-011 SHALL have ports busy_o, done_o, pass_o (output, 1 each), errors_o (output, CNT_BITS) and err_addr_o (output, ADDRS).
REQ-012 SHALL have AW channel axi_aw{valid,ready,addr,id,len,burst} (out, in, out ADDRS, out REQID, out 8, out 2).
REQ-013 SHALL have W channel axi_w{valid,ready,last,strb,data} (out, in, out, out WIDTH/8, out WIDTH).
REQ-014 SHALL have B channel axi_b{valid,ready,resp,id} (in, out, in 2, in REQID).
REQ-015 SHALL have AR channel axi_ar{valid,ready,addr,id,len,burst} and R channel axi_r{valid,ready,last,resp,id,data}, mirroring AW and B/W directions and widths.

Function
REQ-016 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
REQ-017 IDLE + start_i SHALL go to WR_REQ (modes 00/11/01) or RD_REQ (mode 10); bursts_i=0 SHALL go directly to DONE with pass_o=1.
REQ-018 WR_REQ SHALL assert awvalid and wvalid together; each SHALL drop independently on its own handshake; WR_REQ SHALL exit to WR_RESP once the AW handshake and the W-beat with wlast are both complete.
REQ-019 bready SHALL be 1 only in WR_RESP; on the B handshake the FSM SHALL go to WR_REQ for the next burst, or after the last burst to RD_REQ (mode 00) or DONE (mode 01).
REQ-020 RD_REQ SHALL assert arvalid until handshake, then go to RD_DATA with rready=1; after rlast it SHALL go to RD_REQ for the next burst or to DONE.
REQ-021 Exactly one burst SHALL be outstanding at a time.
REQ-022 Burst n address SHALL be base_i + n*(BURST_LEN+1)*WIDTH/8, modulo 2^ADDRS (wrap allowed); awburst/arburst=01; awlen/arlen=BURST_LEN; IDs = n mod 2^REQID; wstrb all ones.
REQ-023 Write data SHALL be a WIDTH-bit Galois LFSR loaded with seed_i (0 replaced by 1) and advanced once per accepted W beat; verify SHALL reload the seed and advance once per accepted R beat.
REQ-024 Each accepted R beat SHALL compare rdata with the LFSR; mismatch, rresp≠00, rid≠expected, or rlast not matching the final beat SHALL each increment errors_o by 1 per beat.
REQ-025 Each B with bresp≠00 or bid≠expected SHALL increment errors_o.
REQ-026 errors_o SHALL saturate at all-ones.
REQ-027 err_addr_o SHALL capture the beat byte address of the first error and hold until the next start.
REQ-028 DONE SHALL assert done_o for one cycle with pass_o=(errors_o==0), then return to IDLE; pass_o, errors_o and err_addr_o SHALL hold until the next accepted start.
REQ-029 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-030 reset_n=0 SHALL asynchronously force IDLE, all valid/ready/last outputs 0, busy_o/done_o/pass_o 0, errors_o 0 and err_addr_o 0, including mid-burst.

Structure
REQ-031 State encoding, LFSR tap constants per WIDTH, and AXI burst/resp constants SHALL live in a shared package axi_ddr3_pkg.
REQ-032 The LFSR SHALL be sub-module bist_lfsr (parameter WIDTH; ports load, seed, step, q), instantiated once and reloaded for verify.

Verification
REQ-033 mode 00, base 0, bursts 2, seed 0x1, always-ready slave with memory model -> 8 W beats at addr 0/16, done_o, pass_o=1, errors_o=0.
REQ-034 As REQ-033 with memory bit 0 of the beat at address 0x14 corrupted -> errors_o=1, err_addr_o=0x14, pass_o=0.
REQ-035 awready delayed 5 cycles after W completes, and the reverse case -> each burst issued exactly once, pass_o=1.
REQ-036 bresp=10 on burst 1, mode 01 -> errors_o=1, no AR issued.
REQ-037 reset_n pulled low in RD_DATA, then start again -> all outputs 0 during reset; rerun passes.
REQ-038 bursts_i=0 -> done_o on the cycle after start, pass_o=1, no AXI traffic.

Source files
------------

// File: rtl/axi_ddr3_pkg.sv
// axi_ddr3_pkg: shared FSM states, AXI constants and LFSR tap masks for the DDR3 BIST.
//   state_e     - BIST controller states
//   BURST_INCR  - AXI INCR burst type; RESP_OKAY - AXI OKAY response
//   MODE_*      - mode_i encodings that change the flow
//   lfsr_taps() - Galois tap mask for a 32/64/128-bit LFSR (bit k-1 set for term x^k)
package axi_ddr3_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_DATA,
        S_DONE
    } state_e;

    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] MODE_WR_ONLY = 2'b01;
    localparam logic [1:0] MODE_VERIFY  = 2'b10;

    // x^32+x^22+x^2+x+1, x^64+x^63+x^61+x^60+1, x^128+x^126+x^101+x^99+1
    localparam logic [31:0]  TAPS_32  = 32'h8020_0003;
    localparam logic [63:0]  TAPS_64  = 64'hD800_0000_0000_0000;
    localparam logic [127:0] TAPS_128 = 128'hA000_0014_0000_0000_0000_0000_0000_0000;

    function automatic logic [127:0] lfsr_taps(input int width);
        return width == 128 ? TAPS_128 : width == 64 ? {64'd0, TAPS_64} : {96'd0, TAPS_32};
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// bist_lfsr: right-shifting Galois LFSR used as the BIST data pattern source.
//   load - load seed (an all-zero seed becomes 1 so the LFSR never locks up)
//   step - advance one state; load wins over step
//   q    - current pattern word
module bist_lfsr
    import axi_ddr3_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = load ? (seed == '0 ? WIDTH'(1) : seed)
            : step ? ({1'b0, q_q[WIDTH-1:1]} ^ (q_q[0] ? TAPS : '0))
            : q_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) q_q <= WIDTH'(1);
        else          q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/axi_ddr3_bist.sv
// axi_ddr3_bist: AXI4 master that writes LFSR bursts to memory and reads them back to verify.
//   start_i/mode_i/base_i/bursts_i/seed_i - test request, sampled when idle
//   busy_o/done_o/pass_o/errors_o/err_addr_o - status; results hold until the next start
//   axi_aw*/axi_w*/axi_b*/axi_ar*/axi_r* - AXI4 master, one burst outstanding at a time
module axi_ddr3_bist
    import axi_ddr3_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDRS     = 27,
    parameter int REQID     = 4,
    parameter int BURST_LEN = 3,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic [ADDRS-1:0]     base_i,
    input  logic [CNT_BITS-1:0]  bursts_i,
    input  logic [WIDTH-1:0]     seed_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [CNT_BITS-1:0]  errors_o,
    output logic [ADDRS-1:0]     err_addr_o,
    output logic                 axi_awvalid,
    input  logic                 axi_awready,
    output logic [ADDRS-1:0]     axi_awaddr,
    output logic [REQID-1:0]     axi_awid,
    output logic [7:0]           axi_awlen,
    output logic [1:0]           axi_awburst,
    output logic                 axi_wvalid,
    input  logic                 axi_wready,
    output logic                 axi_wlast,
    output logic [WIDTH/8-1:0]   axi_wstrb,
    output logic [WIDTH-1:0]     axi_wdata,
    input  logic                 axi_bvalid,
    output logic                 axi_bready,
    input  logic [1:0]           axi_bresp,
    input  logic [REQID-1:0]     axi_bid,
    output logic                 axi_arvalid,
    input  logic                 axi_arready,
    output logic [ADDRS-1:0]     axi_araddr,
    output logic [REQID-1:0]     axi_arid,
    output logic [7:0]           axi_arlen,
    output logic [1:0]           axi_arburst,
    input  logic                 axi_rvalid,
    output logic                 axi_rready,
    input  logic                 axi_rlast,
    input  logic [1:0]           axi_rresp,
    input  logic [REQID-1:0]     axi_rid,
    input  logic [WIDTH-1:0]     axi_rdata
);

    localparam int BYTES       = WIDTH / 8;
    localparam int BURST_BYTES = (BURST_LEN + 1) * BYTES;

    state_e                state_q, state_d;
    logic                  verify_q, verify_d;
    logic [CNT_BITS-1:0]   bursts_q, bursts_d;
    logic [ADDRS-1:0]      base_q, base_d;
    logic [WIDTH-1:0]      seed_q, seed_d;
    logic [CNT_BITS-1:0]   burst_q, burst_d;
    logic [7:0]            beat_q, beat_d;
    logic [ADDRS-1:0]      addr_q, addr_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [CNT_BITS-1:0]   errors_q, errors_d;
    logic [ADDRS-1:0]      err_addr_q, err_addr_d;
    logic                  err_seen_q, err_seen_d;
    logic                  pass_q, pass_d;

    logic                  lfsr_load, lfsr_step, err_hit;
    logic [WIDTH-1:0]      lfsr_seed, lfsr_q;
    logic [ADDRS-1:0]      beat_addr, next_addr, err_at;
    logic [REQID-1:0]      cur_id;
    logic                  last_burst, final_beat;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;

    bist_lfsr #(.WIDTH(WIDTH)) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (lfsr_load),
        .seed    (lfsr_seed),
        .step    (lfsr_step),
        .q       (lfsr_q)
    );

    assign cur_id     = REQID'(burst_q);
    assign beat_addr  = addr_q + ADDRS'(beat_q) * ADDRS'(BYTES);
    assign next_addr  = addr_q + ADDRS'(BURST_BYTES);
    assign last_burst = burst_q == bursts_q - 1'b1;
    assign final_beat = beat_q == 8'(BURST_LEN);

    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid && axi_wready;
    assign b_hs  = axi_bvalid && axi_bready;
    assign ar_hs = axi_arvalid && axi_arready;
    assign r_hs  = axi_rvalid && axi_rready;

    always_comb begin
        state_d    = state_q;
        verify_d   = verify_q;
        bursts_d   = bursts_q;
        base_d     = base_q;
        seed_d     = seed_q;
        burst_d    = burst_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        errors_d   = errors_q;
        err_addr_d = err_addr_q;
        err_seen_d = err_seen_q;
        pass_d     = pass_q;
        lfsr_load  = 1'b0;
        lfsr_seed  = seed_q;
        lfsr_step  = 1'b0;
        err_hit    = 1'b0;
        err_at     = beat_addr;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    verify_d   = mode_i != MODE_WR_ONLY;
                    bursts_d   = bursts_i;
                    base_d     = base_i;
                    seed_d     = seed_i;
                    burst_d    = '0;
                    beat_d     = '0;
                    addr_d     = base_i;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    errors_d   = '0;
                    err_addr_d = '0;
                    err_seen_d = 1'b0;
                    pass_d     = 1'b0;
                    lfsr_load  = 1'b1;
                    lfsr_seed  = seed_i;
                    state_d    = bursts_i == '0 ? S_DONE : mode_i == MODE_VERIFY ? S_RD_REQ : S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                // AW and W complete independently; the burst is issued once both have.
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs) begin
                    lfsr_step = 1'b1;
                    beat_d    = axi_wlast ? '0 : beat_q + 1'b1;
                    w_done_d  = axi_wlast;
                end
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (b_hs) begin
                    err_hit = axi_bresp != RESP_OKAY || axi_bid != cur_id;
                    err_at  = addr_q;
                    burst_d = last_burst ? '0 : burst_q + 1'b1;
                    addr_d  = last_burst ? base_q : next_addr;
                    // Verify replays the same pattern, so the LFSR restarts from the seed.
                    lfsr_load = last_burst && verify_q;
                    state_d   = !last_burst ? S_WR_REQ : verify_q ? S_RD_REQ : S_DONE;
                end
            end
            S_RD_REQ: begin
                if (ar_hs) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                // The burst ends on the expected beat count so a bad rlast cannot stall the test.
                if (r_hs) begin
                    lfsr_step = 1'b1;
                    err_hit   = axi_rdata != lfsr_q || axi_rresp != RESP_OKAY
                             || axi_rid != cur_id || axi_rlast != final_beat;
                    beat_d    = final_beat ? '0 : beat_q + 1'b1;
                    if (final_beat) begin
                        burst_d = last_burst ? burst_q : burst_q + 1'b1;
                        addr_d  = last_burst ? addr_q : next_addr;
                        state_d = last_burst ? S_DONE : S_RD_REQ;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (err_hit) begin
            errors_d   = &errors_q ? errors_q : errors_q + 1'b1;
            err_addr_d = err_seen_q ? err_addr_q : err_at;
            err_seen_d = 1'b1;
        end
        if (state_d == S_DONE) pass_d = errors_d == '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            verify_q   <= 1'b0;
            bursts_q   <= '0;
            base_q     <= '0;
            seed_q     <= '0;
            burst_q    <= '0;
            beat_q     <= '0;
            addr_q     <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            errors_q   <= '0;
            err_addr_q <= '0;
            err_seen_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            verify_q   <= verify_d;
            bursts_q   <= bursts_d;
            base_q     <= base_d;
            seed_q     <= seed_d;
            burst_q    <= burst_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            errors_q   <= errors_d;
            err_addr_q <= err_addr_d;
            err_seen_q <= err_seen_d;
            pass_q     <= pass_d;
        end
    end

    assign busy_o      = state_q != S_IDLE;
    assign done_o      = state_q == S_DONE;
    assign pass_o      = pass_q;
    assign errors_o    = errors_q;
    assign err_addr_o  = err_addr_q;

    assign axi_awvalid = state_q == S_WR_REQ && !aw_done_q;
    assign axi_awaddr  = addr_q;
    assign axi_awid    = cur_id;
    assign axi_awlen   = 8'(BURST_LEN);
    assign axi_awburst = BURST_INCR;
    assign axi_wvalid  = state_q == S_WR_REQ && !w_done_q;
    assign axi_wlast   = axi_wvalid && final_beat;
    assign axi_wstrb   = '1;
    assign axi_wdata   = lfsr_q;
    assign axi_bready  = state_q == S_WR_RESP;
    assign axi_arvalid = state_q == S_RD_REQ;
    assign axi_araddr  = addr_q;
    assign axi_arid    = cur_id;
    assign axi_arlen   = 8'(BURST_LEN);
    assign axi_arburst = BURST_INCR;
    assign axi_rready  = state_q == S_RD_DATA;

endmodule

// File: tb/tb_axi_ddr3_bist.sv
// tb_axi_ddr3_bist: table-driven bench with an AXI slave memory model and expected-traffic scoreboard.
module tb_axi_ddr3_bist;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  mode_i = '0;
    logic [26:0] base_i = '0;
    logic [15:0] bursts_i = '0;
    logic [31:0] seed_i = '0;
    logic        busy_o, done_o, pass_o;
    logic [15:0] errors_o;
    logic [26:0] err_addr_o;
    logic        axi_awvalid, axi_awready = 1'b0;
    logic [26:0] axi_awaddr;
    logic [3:0]  axi_awid;
    logic [7:0]  axi_awlen;
    logic [1:0]  axi_awburst;
    logic        axi_wvalid, axi_wready = 1'b0, axi_wlast;
    logic [3:0]  axi_wstrb;
    logic [31:0] axi_wdata;
    logic        axi_bvalid = 1'b0, axi_bready;
    logic [1:0]  axi_bresp = '0;
    logic [3:0]  axi_bid = '0;
    logic        axi_arvalid, axi_arready = 1'b0;
    logic [26:0] axi_araddr;
    logic [3:0]  axi_arid;
    logic [7:0]  axi_arlen;
    logic [1:0]  axi_arburst;
    logic        axi_rvalid = 1'b0, axi_rready, axi_rlast = 1'b0;
    logic [1:0]  axi_rresp = '0;
    logic [3:0]  axi_rid = '0;
    logic [31:0] axi_rdata = '0;

    always #5 clock = ~clock;

    axi_ddr3_bist dut (
        .clock(clock), .reset_n(reset_n), .start_i(start_i), .mode_i(mode_i),
        .base_i(base_i), .bursts_i(bursts_i), .seed_i(seed_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .errors_o(errors_o), .err_addr_o(err_addr_o),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awburst(axi_awburst),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
        .axi_wstrb(axi_wstrb), .axi_wdata(axi_wdata),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arburst(axi_arburst),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rlast(axi_rlast),
        .axi_rresp(axi_rresp), .axi_rid(axi_rid), .axi_rdata(axi_rdata)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [26:0] base;
        logic [15:0] bursts;
        logic [31:0] seed;
        int          corrupt;
        int          bad_b;
        int          dly;
        int          exp_err;
        bit          exp_pass;
        logic [26:0] exp_eaddr;
        int          exp_aw;
        int          exp_ar;
    } test_t;

    typedef struct { logic [26:0] addr; logic [3:0] id; } req_t;
    typedef struct { logic [26:0] addr; logic [31:0] data; logic last; } beat_t;

    test_t       tests [10];
    logic [31:0] mem [int];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cur = 0;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL test%0d %s: got 0x%0h expected 0x%0h", cur, name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_pass"}, pass_o, 0);
        check({tag, "_errors"}, errors_o, 0);
        check({tag, "_err_addr"}, err_addr_o, 0);
        check({tag, "_handshakes"}, {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, axi_arvalid, axi_rready}, 0);
    endtask

    task automatic slave_idle();
        axi_bvalid = 1'b0;
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        axi_arready = 1'b1;
    endtask

    task automatic run_test(input test_t t, input bit stop_rd);
        req_t        exp_aw_q[$], exp_ar_q[$], rd_q[$], rq;
        beat_t       exp_w_q[$], bt;
        logic [3:0]  aw_ids[$];
        logic [31:0] lf;
        logic [26:0] a, ra;
        int          cyc = 0, aw_cnt = 0, wl_cnt = 0, ar_cnt = 0, b_iss = 0, r_beat = 0, wait_ctr = 0;
        bit          got_done = 0, stopped = 0, bv, n_awr, n_wr;
        lf = t.seed == 0 ? 32'h1 : t.seed;
        for (int n = 0; n < int'(t.bursts); n++) begin
            a = t.base + 27'(n * 16);
            if (t.mode != 2'b10) begin
                exp_aw_q.push_back('{a, 4'(n)});
                for (int b = 0; b < 4; b++) begin
                    exp_w_q.push_back('{a + 27'(b * 4), lf, b == 3});
                    lf = lfsr_next(lf);
                end
            end
            if (t.mode != 2'b01) exp_ar_q.push_back('{a, 4'(n)});
        end
        slave_idle();
        axi_awready = t.dly != 1;
        axi_wready  = t.dly != 2;
        @(posedge clock); #1;
        mode_i = t.mode; base_i = t.base; bursts_i = t.bursts; seed_i = t.seed; start_i = 1'b1;
        @(posedge clock); #1;
        while (!got_done && !stopped && cyc < 3000) begin
            @(negedge clock);
            cyc++;
            if (stop_rd && axi_rready) begin
                stopped = 1;
                break;
            end
            if (done_o) begin
                got_done = 1;
                check("pass_at_done", pass_o, t.exp_pass);
                check("errors", errors_o, 64'(t.exp_err));
                check("err_addr", err_addr_o, t.exp_eaddr);
                check("busy_at_done", busy_o, 1);
            end
            if (axi_awvalid && axi_awready) begin
                if (exp_aw_q.size() == 0) check("aw_extra", 1, 0);
                else begin
                    rq = exp_aw_q.pop_front();
                    check("aw_addr", axi_awaddr, rq.addr);
                    check("aw_id", axi_awid, rq.id);
                    check("aw_len_burst", {axi_awlen, axi_awburst}, {8'd3, 2'b01});
                end
                aw_ids.push_back(axi_awid);
                aw_cnt++;
            end
            if (axi_wvalid && axi_wready) begin
                if (exp_w_q.size() == 0) check("w_extra", 1, 0);
                else begin
                    bt = exp_w_q.pop_front();
                    check("w_data", axi_wdata, bt.data);
                    check("w_last_strb", {axi_wlast, axi_wstrb}, {bt.last, 4'hF});
                    mem[int'(bt.addr)] = axi_wdata ^ {31'd0, int'(bt.addr) == t.corrupt};
                end
                if (axi_wlast) wl_cnt++;
            end
            bv = axi_bvalid && !axi_bready;
            if (axi_arvalid && axi_arready) begin
                if (exp_ar_q.size() == 0) check("ar_extra", 1, 0);
                else begin
                    rq = exp_ar_q.pop_front();
                    check("ar_addr", axi_araddr, rq.addr);
                    check("ar_id", axi_arid, rq.id);
                    check("ar_len_burst", {axi_arlen, axi_arburst}, {8'd3, 2'b01});
                end
                rd_q.push_back('{axi_araddr, axi_arid});
                ar_cnt++;
            end
            if (axi_rvalid && axi_rready) begin
                r_beat++;
                if (r_beat == 4) begin
                    r_beat = 0;
                    void'(rd_q.pop_front());
                end
            end
            wait_ctr = ((t.dly == 1 && wl_cnt > aw_cnt) || (t.dly == 2 && aw_cnt > wl_cnt)) ? wait_ctr + 1 : 0;
            n_awr = t.dly != 1 || (wl_cnt > aw_cnt && wait_ctr >= 5);
            n_wr  = t.dly != 2 || (aw_cnt > wl_cnt && wait_ctr >= 5);
            @(posedge clock); #1;
            if (cyc == 1) start_i = 1'b0;
            axi_awready = n_awr;
            axi_wready  = n_wr;
            if (!bv && aw_cnt > b_iss && wl_cnt > b_iss) begin
                bv = 1;
                axi_bid   = aw_ids[b_iss];
                axi_bresp = b_iss == t.bad_b ? 2'b10 : 2'b00;
                b_iss++;
            end
            axi_bvalid = bv;
            axi_rvalid = rd_q.size() > 0;
            if (rd_q.size() > 0) begin
                ra = rd_q[0].addr + 27'(r_beat * 4);
                axi_rdata = mem.exists(int'(ra)) ? mem[int'(ra)] : 32'h0;
                axi_rid   = rd_q[0].id;
                axi_rlast = r_beat == 3;
                axi_rresp = 2'b00;
            end
        end
        start_i = 1'b0;
        if (stopped) return;
        check("done_seen", got_done, 1);
        check("aw_count", aw_cnt, t.exp_aw);
        check("b_count", b_iss, t.exp_aw);
        check("ar_count", ar_cnt, t.exp_ar);
        check("w_left", exp_w_q.size(), 0);
        if (t.bursts == 0) check("done_latency", cyc, 1);
        slave_idle();
        @(negedge clock);
        check("done_pulse_end", {done_o, busy_o}, 0);
        check("pass_hold", pass_o, t.exp_pass);
        check("errors_hold", errors_o, 64'(t.exp_err));
    endtask

    initial begin
        tests[0] = '{2'd0, 27'h0,       16'd2, 32'h1, -1,   -1, 0, 0,  1'b1, 27'h0,   2, 2};
        tests[1] = '{2'd0, 27'h0,       16'd2, 32'h1, 'h14, -1, 0, 1,  1'b0, 27'h14,  2, 2};
        tests[2] = '{2'd1, 27'h100,     16'd3, 32'h5, -1,   -1, 0, 0,  1'b1, 27'h0,   3, 0};
        tests[3] = '{2'd2, 27'h100,     16'd3, 32'h5, -1,   -1, 0, 0,  1'b1, 27'h0,   0, 3};
        tests[4] = '{2'd2, 27'h100,     16'd3, 32'h6, -1,   -1, 0, 12, 1'b0, 27'h100, 0, 3};
        tests[5] = '{2'd3, 27'h7FFFFF8, 16'd2, 32'h0, -1,   -1, 0, 0,  1'b1, 27'h0,   2, 2};
        tests[6] = '{2'd0, 27'h200,     16'd0, 32'h9, -1,   -1, 0, 0,  1'b1, 27'h0,   0, 0};
        tests[7] = '{2'd1, 27'h40,      16'd2, 32'h3, -1,    1, 0, 1,  1'b0, 27'h50,  2, 0};
        tests[8] = '{2'd0, 27'h300,     16'd2, 32'h7, -1,   -1, 1, 0,  1'b1, 27'h0,   2, 2};
        tests[9] = '{2'd0, 27'h300,     16'd2, 32'h7, -1,   -1, 2, 0,  1'b1, 27'h0,   2, 2};
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("por");
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cur = i;
            run_test(tests[i], 1'b0);
        end
        cur = 10;
        run_test(tests[0], 1'b1);
        check("reached_rd_data", axi_rready, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_rd");
        slave_idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("held_rd");
        reset_n = 1'b1;
        cur = 11;
        run_test(tests[0], 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
